// File: rtl/odo_pipe_scheduler_pkg.sv
// odo_pipe_scheduler_pkg: shared block width, block type and scheduler state encoding (package odo_pkg).
package odo_pkg;
   localparam int BLK_W = 640;
   localparam int ODO_BLK_WORDS = 20;
   typedef logic [BLK_W-1:0] odo_blk_t;
   typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} sched_state_t;
endpackage

// File: rtl/odo_pipe_scheduler_if.sv
// odo_pipe_scheduler_if: requester, core and result signals of the shared odo_encrypt scheduler.
interface odo_pipe_scheduler_if #(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ),
   parameter int BLK_W = odo_pkg::BLK_W
);
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ*BLK_W-1:0] req_data;
   logic [BLK_W-1:0] core_in;
   logic core_read;
   logic [BLK_W-1:0] core_out;
   logic core_write;
   logic res_valid;
   logic [ID_W-1:0] res_id;
   logic [BLK_W-1:0] res_data;
   modport master (
      output req_valid, req_data, core_out, core_write,
      input req_ready, core_in, core_read, res_valid, res_id, res_data
   );
   modport slave (
      input req_valid, req_data, core_out, core_write,
      output req_ready, core_in, core_read, res_valid, res_id, res_data
   );
endinterface

// File: rtl/odo_pipe_scheduler_tag_fifo.sv
// odo_tag_fifo: in-order tag FIFO; pointers wrap modulo DEPTH (power of 2), count is 0..DEPTH.
module odo_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic reset,
   input logic push,
   input logic pop,
   input logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic empty,
   output logic full,
   output logic [AW:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic do_push, do_pop;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign dout = mem[rd];
   always_ff @(posedge clk) if (do_push) mem[wr] <= din;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/odo_pipe_scheduler.sv
// odo_pipe_scheduler: round-robin sharing of one odo_encrypt pipeline with in-order result routing.
// Optional stall-on-hang watchdog enabled by defining ODO_SCHED_WATCHDOG_EN.
module odo_pipe_scheduler
   import odo_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ),
   parameter int BLK_W = odo_pkg::BLK_W,
   parameter int MAX_INFLIGHT = 8,
   parameter int ISSUE_GAP = 4,
   parameter int CORE_LAT = 24,
   localparam int CW = $clog2(MAX_INFLIGHT) + 1
) (
   input logic clk,
   input logic reset,
   odo_pipe_scheduler_if.slave bus,
   output logic [CW-1:0] inflight,
   output logic busy,
   output logic err_orphan
`ifdef ODO_SCHED_WATCHDOG_EN
   , output logic wd_timeout
`endif
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_GRANT = GRANT;
   localparam logic [1:0] S_COOL = COOLDOWN;
   localparam int GW = $clog2(ISSUE_GAP + 1);
   logic [1:0] state;
   logic [ID_W-1:0] ptr, g, idx, head;
   logic [GW-1:0] gap;
   logic hit, push, pop, empty, full, wd_ok;
   // Winner is re-evaluated in GRANT, so a requester that dropped valid is skipped.
   always_comb begin
      hit = 1'b0;
      g = '0;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            hit = 1'b1;
            g = idx;
         end
      end
   end
   assign push = state == S_GRANT && hit;
   assign pop = bus.core_write && !empty;
   assign bus.req_ready = push ? NREQ'(1) << g : '0;
   assign busy = inflight != '0 || state != S_IDLE;
   odo_tag_fifo #(.DEPTH(MAX_INFLIGHT), .WIDTH(ID_W)) u_tags (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(g),
      .dout(head), .empty(empty), .full(full), .count(inflight)
   );
`ifdef ODO_SCHED_WATCHDOG_EN
   localparam int WW = $clog2(2 * CORE_LAT + 1);
   logic [WW-1:0] wd_cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= '0;
         wd_timeout <= 1'b0;
      end else if (bus.core_write || inflight == '0) wd_cnt <= '0;
      else if (wd_cnt == WW'(2 * CORE_LAT - 1)) wd_timeout <= 1'b1;
      else wd_cnt <= wd_cnt + 1'b1;
   end
   assign wd_ok = !wd_timeout;
`else
   assign wd_ok = 1'b1;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         ptr <= '0;
         gap <= '0;
         bus.core_in <= '0;
         bus.core_read <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_id <= '0;
         bus.res_data <= '0;
         err_orphan <= 1'b0;
      end else begin
         bus.core_read <= push;
         if (push) bus.core_in <= bus.req_data[g*BLK_W +: BLK_W];
         bus.res_valid <= bus.core_write;
         if (bus.core_write) begin
            bus.res_id <= empty ? '0 : head;
            bus.res_data <= bus.core_out;
            if (empty) err_orphan <= 1'b1;
         end
         case (state)
            S_IDLE: if (|bus.req_valid && !full && gap == '0 && wd_ok) state <= S_GRANT;
            S_GRANT: begin
               state <= (hit && ISSUE_GAP > 1) ? S_COOL : S_IDLE;
               if (hit) begin
                  gap <= GW'(ISSUE_GAP - 1);
                  ptr <= (g == ID_W'(NREQ - 1)) ? '0 : g + 1'b1;
               end
            end
            S_COOL: begin
               gap <= gap - 1'b1;
               if (gap <= GW'(1)) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_odo_pipe_scheduler.sv
// tb_odo_pipe_scheduler: directed scoreboard bench with a latency-programmable core model.
module tb_odo_pipe_scheduler;
   localparam int NREQ = 4, ID_W = 2, BLK_W = 640;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   odo_pipe_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W), .BLK_W(BLK_W)) bus ();
   logic [3:0] inflight;
   logic busy, err_orphan;
`ifdef ODO_SCHED_WATCHDOG_EN
   logic wd_timeout;
`endif
   odo_pipe_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .BLK_W(BLK_W), .MAX_INFLIGHT(8),
      .ISSUE_GAP(4), .CORE_LAT(24)) dut (
      .clk(clk), .reset(reset), .bus(bus), .inflight(inflight), .busy(busy),
      .err_orphan(err_orphan)
`ifdef ODO_SCHED_WATCHDOG_EN
      , .wd_timeout(wd_timeout)
`endif
   );
   typedef struct {int due; logic [BLK_W-1:0] d;} job_t;
   typedef struct {logic [ID_W-1:0] id; logic [BLK_W-1:0] d;} res_t;
   int n_cmp = 0, n_bad = 0, cyc = 0, phase = 0, lat = 24, last_cr = -1, n_cr = 0;
   int left [NREQ] = '{default: 0};
   bit drop = 0, inj = 0, tight = 0, chk_lat = 0, chk_inf3 = 0;
   logic [BLK_W-1:0] inj_d;
   logic [NREQ-1:0] taken = '0, rdy_prev = '0;
   job_t pend [$];
   res_t rq [$];
   logic [ID_W-1:0] gq [$];
   logic [ID_W-1:0] mg;
   res_t mr;
   function automatic logic [BLK_W-1:0] data_for(int i, int ph);
      logic [31:0] w;
      w = {8'(i), 8'(ph), 16'hBEEF};
      return {20{w}};
   endfunction
   function automatic logic [BLK_W-1:0] core_f(logic [BLK_W-1:0] x);
      return ~{x[BLK_W-33:0], x[BLK_W-1 -: 32]};
   endfunction
   task automatic check(string name, logic [BLK_W-1:0] act, logic [BLK_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i] = left[i] != 0;
         bus.req_data[i*BLK_W +: BLK_W] = data_for(i, phase);
      end
   end
   // Requester bookkeeping: a grant seen during GRANT retires one block after the edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      for (int i = 0; i < NREQ; i++) if (taken[i] && left[i] > 0) left[i]--;
      taken = '0;
   end
   // Core model: result appears lat cycles after core_read, registered like a pipeline output.
   always @(negedge clk) begin
      job_t j;
      if (bus.core_read) begin
         j.due = cyc + lat;
         j.d = core_f(bus.core_in);
         pend.push_back(j);
      end
      bus.core_write = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         if (!drop) begin
            bus.core_write = 1'b1;
            bus.core_out = pend[0].d;
         end
         void'(pend.pop_front());
      end else if (inj) begin
         bus.core_write = 1'b1;
         bus.core_out = inj_d;
         inj = 0;
      end
   end
   // Monitor: checks each issue against the expected grant order and each result against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.core_read) begin
            if (gq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_core_read: got core_read=1 at cycle %0d expected none", cyc);
            end else begin
               mg = gq.pop_front();
               check("grant_onehot", rdy_prev, NREQ'(1) << mg);
               check("core_in", bus.core_in, data_for(int'(mg), phase));
               if (last_cr >= 0) begin
                  if (tight) check("issue_gap", cyc - last_cr, 5);
                  else check("issue_gap_min", cyc - last_cr >= 5, 1);
               end
               if (chk_inf3 && n_cr >= 3) check("inflight_push_pop", inflight, 3);
               mr.id = mg;
               mr.d = core_f(data_for(int'(mg), phase));
               rq.push_back(mr);
               last_cr = cyc;
               n_cr++;
            end
         end
         if (bus.res_valid) begin
            if (rq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_res_valid: got res_id=%0d expected no result", bus.res_id);
            end else begin
               mr = rq.pop_front();
               check("res_id", bus.res_id, mr.id);
               check("res_data", bus.res_data, mr.d);
               if (chk_lat) check("res_latency", cyc - last_cr, 25);
            end
         end
      end
      rdy_prev = bus.req_ready;
      taken = bus.req_ready;
   end
   function automatic bit all_done();
      for (int i = 0; i < NREQ; i++) if (left[i] != 0) return 0;
      return gq.size() == 0 && rq.size() == 0 && pend.size() == 0 && !busy;
   endfunction
   task automatic wait_done(string name, int budget);
      int n = 0;
      while (!all_done() && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!all_done()) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got %0d grants and %0d results pending expected none", name, gq.size(), rq.size());
         gq.delete();
         rq.delete();
         pend.delete();
         for (int i = 0; i < NREQ; i++) left[i] = 0;
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      last_cr = -1;
      n_cr = 0;
   endtask
   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL global_timeout: got no end of test expected finish");
      $fatal(1, "bench timeout");
   end
   initial begin
      bit ok;
      int n;
      bus.core_write = 1'b0;
      bus.core_out = '0;
      do_reset();
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_core_read", bus.core_read, 0);
      check("rst_core_in", bus.core_in, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_id", bus.res_id, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_inflight", inflight, 0);
      check("rst_busy", busy, 0);
      check("rst_err_orphan", err_orphan, 0);
      // Single requester 2, latency 24.
      phase = 1;
      chk_lat = 1;
      gq.push_back(2'd2);
      left[2] = 1;
      wait_done("single", 200);
      chk_lat = 0;
      check("no_orphan", err_orphan, 0);
      // All requesters valid: strict round robin at peak rate.
      do_reset();
      phase = 2;
      tight = 1;
      for (int r = 0; r < 2; r++) for (int i = 0; i < NREQ; i++) gq.push_back(ID_W'(i));
      for (int i = 0; i < NREQ; i++) left[i] = 2;
      repeat (3) @(negedge clk);
      check("busy_active", busy, 1);
      wait_done("round_robin", 400);
      tight = 0;
      // Long core latency: issue stalls at 8 outstanding.
      do_reset();
      phase = 3;
      lat = 100;
      for (int i = 0; i < 10; i++) gq.push_back(2'd1);
      left[1] = 10;
      n = 0;
      while (inflight != 4'd8 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("inflight_full", inflight, 8);
      ok = 1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!bus.core_write && bus.req_ready != '0) ok = 0;
      end while (!bus.core_write && n < 150);
      check("ready_blocked", ok, 1);
      check("issued_before_pop", n_cr, 8);
      check("inflight_after_pop", inflight, 7);
      wait_done("max_inflight", 1000);
      lat = 24;
      // Pop and push on the same edge keep inflight at 3.
      do_reset();
      phase = 4;
      lat = 14;
      tight = 1;
      chk_inf3 = 1;
      for (int r = 0; r < 3; r++) begin
         gq.push_back(2'd0);
         gq.push_back(2'd1);
      end
      left[0] = 3;
      left[1] = 3;
      wait_done("push_pop", 300);
      chk_inf3 = 0;
      tight = 0;
      lat = 24;
      // Orphan result with nothing issued.
      do_reset();
      phase = 5;
      inj_d = data_for(3, 5);
      mr.id = '0;
      mr.d = inj_d;
      rq.push_back(mr);
      @(posedge clk);
      inj = 1;
      repeat (5) @(negedge clk);
      check("orphan_flag", err_orphan, 1);
      check("orphan_inflight", inflight, 0);
      check("orphan_res_seen", rq.size(), 0);
      repeat (20) @(negedge clk);
      check("orphan_sticky", err_orphan, 1);
      rq.delete();
`ifdef ODO_SCHED_WATCHDOG_EN
      // Lost result: watchdog trips and blocks further issue.
      do_reset();
      phase = 6;
      drop = 1;
      gq.push_back(2'd0);
      left[0] = 1;
      n = 0;
      while (n_cr == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      rq.delete();
      repeat (40) @(negedge clk);
      check("wd_not_early", wd_timeout, 0);
      repeat (20) @(negedge clk);
      check("wd_timeout", wd_timeout, 1);
      n = n_cr;
      left[1] = 1;
      repeat (30) @(negedge clk);
      check("wd_blocks_issue", n_cr, n);
      check("wd_sticky", wd_timeout, 1);
      left[1] = 0;
      drop = 0;
      do_reset();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/odo_pipe_scheduler.md
Name: odo_pipe_scheduler

Overview:
- Shares one odo_encrypt pipeline (640-bit block in, 640-bit block out, fixed latency) between NREQ block requesters.
- Round-robin arbitration; issues one block per grant with a minimum issue spacing.
- Tags each issued block with its requester ID in an in-order tag FIFO; routes each core result back with that ID.
- Sits between the nonce/work generators and odo_encrypt in the miner top.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, equals clog2(NREQ)
- BLK_W, 640, block width
- MAX_INFLIGHT, 8, outstanding-job limit; this is also the tag FIFO depth (power of 2)
- ISSUE_GAP, 4, minimum cycles between core_read pulses (≥1)
- CORE_LAT, 24, nominal core latency in cycles, used by the optional watchdog

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester block valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_data  in  NREQ*BLK_W  requester i occupies bits [i*BLK_W +: BLK_W]
- core_in  out  BLK_W  block to odo_encrypt
- core_read  out  1  one-cycle issue pulse to odo_encrypt
- core_out  in  BLK_W  result from odo_encrypt
- core_write  in  1  result-valid pulse from odo_encrypt
- res_valid  out  1  routed result valid, single cycle, no backpressure
- res_id  out  ID_W  requester the result belongs to
- res_data  out  BLK_W  result block
- inflight  out  clog2(MAX_INFLIGHT)+1  outstanding job count
- busy  out  1  inflight≠0 or state≠IDLE
- err_orphan  out  1  sticky: core_write seen with the tag FIFO empty

Behaviour:
- Reset: every output 0, state IDLE, round-robin pointer 0, tag FIFO empty, gap counter 0, err_orphan cleared.
- States:
  - IDLE: if any req_valid, inflight<MAX_INFLIGHT and gap counter==0, go to GRANT.
  - GRANT: exactly one cycle. Pick the first valid requester at or after the pointer (wrapping). In that cycle:
    - assert req_ready[g]
    - register req_data[g] into core_in
    - assert core_read
    - push g into the tag FIFO
    - load gap counter with ISSUE_GAP-1
    - set pointer to g+1 mod NREQ
    - go to COOLDOWN, or to IDLE if ISSUE_GAP==1
  - If the winner has dropped valid by GRANT, grant nobody and go back to IDLE.
  - COOLDOWN: decrement the gap counter; go to IDLE when it reaches 0.
- Timing:
  - core_in and core_read are registered and change together.
  - Accept-to-core_read latency is 1 cycle after the GRANT decision; the IDLE→GRANT decision is 1 cycle.
  - Peak issue rate is 1 per ISSUE_GAP+1 cycles.
- Result path: on core_write, pop the FIFO head. The next cycle drives res_valid=1, res_id=head, res_data=core_out (registered). Results are in order.
- inflight: +1 on push, −1 on pop, unchanged when both occur in the same cycle. Push is blocked at MAX_INFLIGHT, so the FIFO never overflows.
- core_write with the FIFO empty: set err_orphan, leave inflight unchanged, assert res_valid with res_id=0.
- FIFO pointers are ID-width-agnostic and wrap modulo MAX_INFLIGHT.
- Reset mid-operation drops all tags; results for jobs already in the core then arrive as orphans. Integration must reset the core concurrently.

Optional Feature:
- Macro ODO_SCHED_WATCHDOG_EN.
- When defined:
  - Adds output wd_timeout (1 bit, sticky until reset).
  - A counter runs while inflight≠0, clears on each core_write, and sets wd_timeout when it reaches 2*CORE_LAT.
  - While wd_timeout=1, no new grants are issued.
- When undefined: the port is absent, there is no counter, and grants depend only on inflight and the gap counter.

Decomposition:
- Package odo_pkg holds:
  - BLK_W and ODO_BLK_WORDS=20
  - typedef odo_blk_t (logic [BLK_W-1:0])
  - enum sched_state_t {IDLE, GRANT, COOLDOWN}
- Sub-module odo_tag_fifo: synchronous FIFO with parameters depth and width; ports push, pop, din, dout, empty, full, count.
- The arbiter stays inline.

Test Plan:
- Single requester 2 valid, ISSUE_GAP=4, core model latency 24: core_read one cycle after decision with core_in=req_data[2]; res_valid 25 cycles after core_read with res_id=2, res_data=model output.
- All 4 requesters valid continuously: grant order 0,1,2,3,0…; core_read spaced exactly 5 cycles apart; each requester gets 1 grant per 4 issues.
- Model latency 100, MAX_INFLIGHT=8: after 8 issues, inflight=8 and req_ready stays 0 until the first core_write; inflight then returns to 7 and issue resumes.
- core_write and a push in the same cycle with inflight=3: inflight stays 3; FIFO order preserved (res_id sequence matches grant sequence).
- core_write injected after reset with no issue: err_orphan=1 and stays 1; inflight stays 0.
- With ODO_SCHED_WATCHDOG_EN and CORE_LAT=24, model drops a result: wd_timeout=1 48 cycles after the last core_write while inflight≠0; no further core_read.
